// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared geometry, address bit positions and FSM states
package cache_controller_pkg;
    localparam int SETS    = 64;
    localparam int TAG_W   = 11;
    localparam int IDX_LSB = 2;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
endpackage

// File: rtl/cache_controller_array.sv
// cache_array: 2-way storage with per-set LRU; only valid and LRU bits are reset
module cache_array #(
    parameter int SETS  = cache_controller_pkg::SETS,
    parameter int TAG_W = cache_controller_pkg::TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(SETS)-1:0]    index,
    output logic [1:0][31:0]           rd_data,
    output logic [1:0][TAG_W-1:0]      rd_tag,
    output logic [1:0]                 rd_valid,
    output logic                       lru,
    input  logic                       we,
    input  logic                       way,
    input  logic [TAG_W-1:0]           wtag,
    input  logic [31:0]                wdata,
    input  logic                       lru_we,
    input  logic                       lru_val
);
    logic [31:0]      data  [2][SETS];
    logic [TAG_W-1:0] tag   [2][SETS];
    logic [SETS-1:0]  valid [2];
    logic [SETS-1:0]  lru_bits;

    always_ff @(posedge clk) begin
        if (we) begin
            data[way][index] <= wdata;
            tag[way][index]  <= wtag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru_bits <= '0;
        end else begin
            if (we) valid[way][index] <= 1'b1;
            if (lru_we) lru_bits[index] <= lru_val;
        end
    end

    assign rd_data[0]  = data[0][index];
    assign rd_data[1]  = data[1][index];
    assign rd_tag[0]   = tag[0][index];
    assign rd_tag[1]   = tag[1][index];
    assign rd_valid[0] = valid[0][index];
    assign rd_valid[1] = valid[1][index];
    assign lru         = lru_bits[index];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way write-through, no-write-allocate data cache in front of an SRAM controller
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS  = cache_controller_pkg::SETS,
    parameter int TAG_W = cache_controller_pkg::TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] rdata,
    output logic        pause,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_pause
);
    localparam int IW = $clog2(SETS);
    localparam int TL = IDX_LSB + IW;

    state_t state, next;
    logic [IW-1:0]        index;
    logic [TAG_W-1:0]     tag;
    logic [1:0][31:0]     rd_data;
    logic [1:0][TAG_W-1:0] rd_tag;
    logic [1:0]           rd_valid, hit_vec;
    logic                 lru, hit, hit_way, done, any_req;
    logic                 we, way, lru_we, lru_val, pause_c;
    logic [31:0]          rdata_c;

    assign index   = address[IDX_LSB +: IW];
    assign tag     = address[TL +: TAG_W];
    assign hit_vec = {rd_valid[1] && rd_tag[1] == tag, rd_valid[0] && rd_tag[0] == tag};
    assign hit     = |hit_vec;
    assign hit_way = hit_vec[1];
    assign done    = state != IDLE && !sram_pause;
    assign any_req = rd_en || wr_en;

    cache_array #(.SETS(SETS), .TAG_W(TAG_W)) u_array (
        .clk(clk), .rst(rst), .index(index),
        .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid), .lru(lru),
        .we(we && !rst), .way(way), .wtag(tag), .wdata(state == RD_WAIT ? sram_rdata : write_data),
        .lru_we(lru_we && !rst), .lru_val(lru_val)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : next;

    always_comb begin
        next    = state;
        pause_c = 1'b0;
        rdata_c = '0;
        we      = 1'b0;
        way     = 1'b0;
        lru_we  = 1'b0;
        lru_val = 1'b0;
        case (state)
            IDLE: begin
                next    = wr_en ? WR_WAIT : (rd_en && !hit) ? RD_WAIT : IDLE;
                pause_c = wr_en || (rd_en && !hit);
                if (!wr_en && rd_en && hit) begin
                    rdata_c = rd_data[hit_way];
                    lru_we  = 1'b1;
                    lru_val = !hit_way;
                end
            end
            RD_WAIT: begin
                pause_c = !done;
                if (!any_req) next = IDLE;
                else if (done) begin
                    next    = IDLE;
                    rdata_c = sram_rdata;
                    we      = 1'b1;
                    way     = lru;
                    lru_we  = 1'b1;
                    lru_val = !lru;
                end
            end
            WR_WAIT: begin
                pause_c = !done;
                if (!any_req) next = IDLE;
                else if (done) begin
                    next    = IDLE;
                    we      = hit;
                    way     = hit_way;
                    lru_we  = hit;
                    lru_val = !hit_way;
                end
            end
            default: next = IDLE;
        endcase
    end

    // reset silences the request/handshake outputs in the very cycle it is asserted
    assign pause        = pause_c && !rst;
    assign rdata        = rst ? '0 : rdata_c;
    assign sram_rd_en   = state == RD_WAIT && !rst;
    assign sram_wr_en   = state == WR_WAIT && !rst;
    assign sram_address = address;
    assign sram_wdata   = write_data;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed plus random checks against a recency-list cache model
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en, pause, sram_rd_en, sram_wr_en, sram_pause;
    logic [31:0] address, write_data, rdata, sram_address, sram_wdata, sram_rdata;
    int          busy = 0, cnt = 0;
    int          checks = 0, failures = 0;

    logic [31:0] mem [logic [31:0]];
    int          mn [64];
    logic [10:0] mt [64][2];
    logic [31:0] md [64][2];

    cache_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .rdata(rdata), .pause(pause), .sram_rd_en(sram_rd_en),
        .sram_wr_en(sram_wr_en), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_pause(sram_pause)
    );

    always #5 clk = ~clk;

    // SRAM stays busy for `busy` cycles of every access, then completes
    always @(posedge clk) cnt <= (sram_rd_en || sram_wr_en) ? cnt + 1 : 0;
    assign sram_pause = (sram_rd_en || sram_wr_en) && (cnt < busy);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return mem.exists(k) ? mem[k] : (k ^ 32'h5A5A_0F0F);
    endfunction

    function automatic int lookup(input logic [31:0] a);
        int i;
        i = int'(a[7:2]);
        for (int p = 0; p < mn[i]; p++) if (mt[i][p] == a[18:8]) return p;
        return -1;
    endfunction

    // position 0 is most recently used
    function automatic void touch(input int i, input int p);
        logic [10:0] t;
        logic [31:0] d;
        if (p == 1) begin
            t = mt[i][0]; d = md[i][0];
            mt[i][0] = mt[i][1]; md[i][0] = md[i][1];
            mt[i][1] = t; md[i][1] = d;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mn[i] = 0;
    endfunction

    task automatic do_read(input logic [31:0] a, input int b, input string tag);
        int i, p, cyc;
        logic [31:0] exp;
        logic saw_rd;
        i = int'(a[7:2]);
        p = lookup(a);
        exp = p >= 0 ? md[i][p] : mem_val(a);
        @(negedge clk);
        busy = b; address = a; rd_en = 1'b1; wr_en = 1'b0; sram_rdata = mem_val(a);
        #1;
        cyc = 0; saw_rd = sram_rd_en;
        while (pause && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            saw_rd |= sram_rd_en;
        end
        chk({tag, " pause_cycles"}, cyc, p >= 0 ? 0 : b + 1);
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " sram_rd_en"}, {31'b0, saw_rd}, {31'b0, p < 0});
        @(posedge clk); #1;
        rd_en = 1'b0;
        if (p >= 0) touch(i, p);
        else begin
            mt[i][1] = mt[i][0]; md[i][1] = md[i][0];
            mt[i][0] = a[18:8]; md[i][0] = exp;
            mn[i] = mn[i] < 2 ? mn[i] + 1 : 2;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int b,
                            input logic both, input string tag);
        int i, p, cyc;
        logic saw_wr, saw_rd;
        i = int'(a[7:2]);
        p = lookup(a);
        @(negedge clk);
        busy = b; address = a; write_data = d; wr_en = 1'b1; rd_en = both;
        #1;
        cyc = 0; saw_wr = sram_wr_en; saw_rd = sram_rd_en;
        while (pause && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            saw_wr |= sram_wr_en;
            saw_rd |= sram_rd_en;
        end
        chk({tag, " pause_cycles"}, cyc, b + 1);
        chk({tag, " sram_wr_en"}, {31'b0, saw_wr}, 32'd1);
        chk({tag, " sram_rd_en"}, {31'b0, saw_rd}, 32'd0);
        chk({tag, " sram_address"}, sram_address, a);
        chk({tag, " sram_wdata"}, sram_wdata, d);
        chk({tag, " rdata"}, rdata, 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        mem[{a[31:2], 2'b00}] = d;
        if (p >= 0) begin
            md[i][p] = d;
            touch(i, p);
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0; sram_rdata = '0;
        model_reset();
        @(posedge clk); @(negedge clk); #1;
        chk("reset pause", {31'b0, pause}, 32'd0);
        chk("reset sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
        chk("reset sram_wr_en", {31'b0, sram_wr_en}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst = 1'b0;

        mem[32'h400] = 32'hDEAD_BEEF;
        do_read(32'h400, 5, "cold_read_400");
        do_read(32'h400, 5, "repeat_read_400");

        do_read(32'h800, 1, "fill_800");
        do_read(32'hC00, 2, "fill_C00");
        do_read(32'hC00, 0, "hit_C00");
        do_read(32'h800, 0, "hit_800");
        do_read(32'h400, 1, "evicted_400");

        do_write(32'h400, 32'h1234_5678, 3, 1'b0, "write_hit_400");
        do_read(32'h400, 2, "read_after_write_400");

        do_write(32'h1000, 32'hCAFE_F00D, 2, 1'b0, "write_miss_1000");
        do_read(32'h1000, 1, "read_1000");

        do_write(32'h804, 32'hA5A5_5A5A, 1, 1'b1, "both_en_804");

        @(negedge clk); #1;
        chk("idle rdata", rdata, 32'd0);

        for (int n = 0; n < 150; n++) begin
            a = {13'b0, 9'(($urandom_range(0, 3)) << 2) , 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) < 7) do_read(a, $urandom_range(0, 3), "rand_read");
            else do_write(a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand_write");
        end

        do_read(32'h400, 0, "pre_reset_400");
        @(negedge clk);
        busy = 20; address = 32'h2000; rd_en = 1'b1; sram_rdata = mem_val(32'h2000);
        repeat (3) @(negedge clk);
        #1;
        chk("rd_wait sram_rd_en", {31'b0, sram_rd_en}, 32'd1);
        rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("mid_reset pause", {31'b0, pause}, 32'd0);
        chk("mid_reset sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset pause", {31'b0, pause}, 32'd0);
        chk("post_reset sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
        model_reset();
        do_read(32'h400, 1, "after_reset_400");
        do_read(32'h1000, 1, "after_reset_1000");
        do_read(32'hC00, 1, "after_reset_C00");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
